// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants.
// Used by the register file, the rt/rd select stage and the hazard unit.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WR_COUNT_W = 16;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Ports:
//   en_i     - high outside reset; low forces the output to zero
//   raddr_i  - source register address
//   we_i, waddr_i, wdata_i - same-cycle write, used for the bypass
//   regs_i   - flattened storage array
//   rdata_o  - operand (combinational)
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                                en_i,
    input  logic [ADDR_W-1:0]                   raddr_i,
    input  logic                                we_i,
    input  logic [ADDR_W-1:0]                   waddr_i,
    input  logic [DATA_W-1:0]                   wdata_i,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs_i,
    output logic [DATA_W-1:0]                   rdata_o
);

    // Priority: reset, zero register, write-first bypass, storage.
    always_comb begin
        rdata_o = '0;
        if (!en_i) begin
            rdata_o = '0;
        end else if (raddr_i == ADDR_W'(REG_ZERO)) begin
            rdata_o = '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end else begin
            rdata_o = regs_i[raddr_i];
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32 general-purpose register file, two combinational read ports
// with write bypass, one write port, a registered debug read and a
// saturating count of committed writes.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   we, waddr, wdata  - write port (commits on the rising edge)
//   raddr1/rdata1     - rs read port (combinational)
//   raddr2/rdata2     - rt read port (combinational)
//   dbg_addr/dbg_data - debug read, one-cycle latency, no bypass
//   wr_count          - committed writes since reset, saturating
module regfile_2r1w
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     raddr1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [WR_COUNT_W-1:0] wr_count
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [DATA_W-1:0]            dbg_data_q, dbg_data_d;
    logic [WR_COUNT_W-1:0]        wr_count_q, wr_count_d;
    logic                         wr_commit;

    // Writes to the zero register are dropped and not counted.
    assign wr_commit = we && (waddr != ADDR_W'(REG_ZERO));

    always_comb begin
        wr_count_d = wr_count_q;
        if (wr_commit && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + WR_COUNT_W'(1);
        end
    end

    // Debug read sees pre-edge storage only.
    always_comb begin
        dbg_data_d = '0;
        if (dbg_addr != ADDR_W'(REG_ZERO)) begin
            dbg_data_d = regs_q[dbg_addr];
        end
    end

    // Storage; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '0;
            dbg_data_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (wr_commit) begin
                regs_q[waddr] <= wdata;
            end
            dbg_data_q <= dbg_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign dbg_data = dbg_data_q;
    assign wr_count = wr_count_q;

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
        .en_i    (rst_n),
        .raddr_i (raddr1),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .regs_i  (regs_q),
        .rdata_o (rdata1)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
        .en_i    (rst_n),
        .raddr_i (raddr2),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .regs_i  (regs_q),
        .rdata_o (rdata2)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w with an expected-value queue.
module tb_regfile_2r1w;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [15:0] wr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [32];
    int          mcount;
    logic [31:0] exp_q [$];

    regfile_2r1w dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        mcount = 0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d);
        if (a != 5'd0) begin
            model[a] = d;
            if (mcount < 65535) mcount++;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        step();
        model_write(a, d);
        we = 1'b0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        #1 rst_n = 1'b0;

        // Reset state; a write attempt with bypass match must be ignored.
        raddr1 = 5'd5; raddr2 = 5'd31; dbg_addr = 5'd5;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        step(); step();
        push(32'h0); chk("rst_rdata1", rdata1);
        push(32'h0); chk("rst_rdata2", rdata2);
        push(32'h0); chk("rst_dbg", dbg_data);
        push(32'h0); chk("rst_wr_count", 32'(wr_count));
        we = 1'b0;

        // Release and first write.
        @(negedge clk) rst_n = 1'b1;
        do_write(5'd5, 32'h1234_5678);
        push(model[5]); chk("first_write_r5", rdata1);
        push(32'(mcount)); chk("first_write_count", 32'(wr_count));

        // Zero register.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
        #1;
        push(32'h0); chk("zero_during", rdata1);
        step();
        we = 1'b0;
        push(32'h0); chk("zero_after", rdata1);
        push(32'(mcount)); chk("zero_count", 32'(wr_count));

        // Bypass to both ports; debug shows pre-edge then new value.
        do_write(5'd7, 32'hAAAA_0000);
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_5555;
        raddr1 = 5'd7; raddr2 = 5'd7; dbg_addr = 5'd7;
        #1;
        push(32'h0000_5555); chk("bypass_rdata1", rdata1);
        push(32'h0000_5555); chk("bypass_rdata2", rdata2);
        step();
        model_write(5'd7, 32'h0000_5555);
        we = 1'b0;
        push(32'hAAAA_0000); chk("dbg_pre_edge", dbg_data);
        step();
        push(32'h0000_5555); chk("dbg_new", dbg_data);
        push(32'(mcount)); chk("bypass_count", 32'(wr_count));

        // Fresh reset, then full sweep.
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i);
            #1;
            push(model[i]);      chk($sformatf("sweep_rd1_r%0d", i), rdata1);
            push(model[31 - i]); chk($sformatf("sweep_rd2_r%0d", 31 - i), rdata2);
        end
        push(32'd31); chk("sweep_count", 32'(wr_count));
        dbg_addr = 5'd31;
        step();
        push(32'h1F1F_1F1F); chk("sweep_dbg_r31", dbg_data);

        // Async reset between edges.
        @(posedge clk); #2;
        raddr1 = 5'd9; raddr2 = 5'd20;
        #1;
        push(32'h0909_0909); chk("pre_async_r9", rdata1);
        rst_n = 1'b0;
        #1;
        push(32'h0); chk("async_rdata1", rdata1);
        push(32'h0); chk("async_rdata2", rdata2);
        push(32'h0); chk("async_dbg", dbg_data);
        push(32'h0); chk("async_count", 32'(wr_count));
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i);
            #1;
            push(32'h0); chk($sformatf("post_rst_r%0d", i), rdata1);
        end
        push(32'h0); chk("post_rst_count", 32'(wr_count));

        // Saturation of wr_count.
        raddr1 = 5'd1; raddr2 = 5'd0;
        for (int k = 1; k <= 65535; k++) begin
            we = 1'b1; waddr = 5'd1; wdata = 32'(k);
            step();
            model_write(5'd1, 32'(k));
        end
        we = 1'b0;
        push(32'h0000_FFFF); chk("sat_exact", 32'(wr_count));
        for (int k = 65536; k <= 65540; k++) begin
            we = 1'b1; waddr = 5'd1; wdata = 32'(k);
            step();
            model_write(5'd1, 32'(k));
        end
        we = 1'b0;
        #1;
        push(32'h0000_FFFF); chk("sat_hold", 32'(wr_count));
        push(32'd65540); chk("sat_r1_last", rdata1);
        push(model[1]); chk("sat_r1_model", rdata2 | rdata1);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL queue_drain: observed=%0d leftover expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Thirty-two-entry, 32-bit general-purpose register file for the CPU datapath. The register-address select stage chooses the 5-bit destination (rt or rd) and drives it into the write port here. This block is the read side of that address path: it decodes two 5-bit source addresses (rs, rt) into operand data in the same cycle, and commits write-back data on the clock edge. Register 0 is hard-wired to zero, and a same-cycle write is bypassed to both read ports.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W = 32

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset; clears every register
- we  in  1  write enable for the current cycle
- waddr  in  ADDR_W  destination register address, from the rt/rd select stage
- wdata  in  DATA_W  write-back data
- raddr1  in  ADDR_W  source address rs
- raddr2  in  ADDR_W  source address rt
- rdata1  out  DATA_W  operand for rs, combinational
- rdata2  out  DATA_W  operand for rt, combinational
- dbg_addr  in  ADDR_W  debug/board-display read address
- dbg_data  out  DATA_W  registered debug read of dbg_addr
- wr_count  out  16  number of committed writes since reset; saturates at 0xFFFF

## Operation
- Storage: 32 x DATA_W flops. Entry 0 always reads 0.
- Write to entry 0: dropped. Entry 0 stays 0, and wr_count does not increment.
- Write commit: on the rising edge with rst_n=1, we=1 and waddr!=0, set reg[waddr] <= wdata and increment wr_count (saturating).
- Read ports: rdataN = 0 if raddrN==0.
  - Else wdata if we=1 and waddr==raddrN (write-first bypass).
  - Else reg[raddrN].
- Both read ports apply the bypass independently. raddr1==raddr2==waddr bypasses both.
- Debug port: dbg_data <= (dbg_addr==0) ? 0 : reg[dbg_addr] on each edge. It does not apply the bypass, so it shows the pre-edge contents.
- Reset: asynchronous. While rst_n=0:
  - all registers, dbg_data and wr_count are 0;
  - rdata1/rdata2 read 0 regardless of addresses, with the bypass disabled;
  - writes are ignored.
- X/unknown addresses are not legal inputs. The bench must not drive them.

## Timing
- Read latency: 0 cycles. Data is combinational from the addresses and the current state.
- Write latency: 1 edge. The value is visible through storage from the cycle after the edge. In the same cycle it is visible only through the bypass.
- Debug latency: 1 cycle from dbg_addr to dbg_data.
- Reset assertion mid-cycle: outputs clear immediately, not at the next edge.
- Reset deassertion: the first write is accepted at the first rising edge at which rst_n is sampled high.
- Back-to-back writes to the same address: the last edge wins. No hazard state is kept.

## Structure
- Shared package cpu_pkg holds:
  - REG_ADDR_W=5 and DATA_W=32;
  - REG_ZERO=5'd0 and NUM_REGS=32.
  - The rt/rd select stage and the hazard unit use the same constants.
- One sub-module, regfile_read_port. It is instantiated twice and contains:
  - the zero check;
  - the bypass compare;
  - the 32:1 read mux.
- The storage array, write decode, debug register and wr_count live in the top.

## Test plan
- Reset: hold rst_n=0 and drive raddr1=5, raddr2=31. Required: rdata1=rdata2=0, dbg_data=0, wr_count=0. Then release reset, write 0x1234_5678 to r5, and read r5. Required: rdata1 reads 0x1234_5678 the cycle after the edge.
- Zero register: we=1, waddr=0, wdata=0xFFFF_FFFF, raddr1=0 in the same cycle. Required: rdata1=0 during and after the edge, and wr_count unchanged.
- Bypass: r7 holds 0xAAAA_0000. Drive we=1, waddr=7, wdata=0x0000_5555, raddr1=raddr2=7. Required:
  - before the edge, both rdata1 and rdata2 = 0x0000_5555;
  - dbg_addr=7 gives dbg_data=0xAAAA_0000 after that edge;
  - dbg_data gives 0x0000_5555 one cycle later.
- Full sweep: write reg[i]=i*0x0101_0101 for i=1..31. Then read all pairs (i, 31-i). Required: every value matches, r0=0, wr_count=31.
- Async reset mid-operation: assert rst_n=0 between edges after writes. Required: rdata1 goes to 0 before the next edge. After release, every register reads 0 and wr_count=0.
- Saturation: force 65,540 writes to r1. Required: wr_count stops at 0xFFFF, and r1 holds the last wdata.
